// File: rtl/queue_pkg.sv
// queue_pkg: shared widths and types for the circular queue.
//   NUM_OF_BIT  default data word width
//   DEPTH_BITS  default address width (depth = 2^DEPTH_BITS)
//   DEPTH       number of storage entries
//   PTR_W       pointer width: address bits plus one wrap bit
//   ptr_t       pointer type at the default widths
package queue_pkg;

  localparam int NUM_OF_BIT = 10;
  localparam int DEPTH_BITS = 3;
  localparam int DEPTH      = 1 << DEPTH_BITS;
  localparam int PTR_W      = DEPTH_BITS + 1;

  typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/queue_ptr.sv
// queue_ptr: W-bit wrapping pointer counter.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low clear
//   inc    advance the pointer by one on the next edge
//   ptr    current pointer value; MSB is the wrap bit
module queue_ptr
  import queue_pkg::*;
#(
  parameter int W = PTR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // Natural overflow of the W-bit add rolls all-ones back to zero,
  // which toggles the wrap bit whenever the address bits wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/queue_fifo.sv
// queue_fifo: synchronous circular queue between a producer and a consumer.
//   Clk        rising-edge clock
//   Rst_n      asynchronous active-low reset (pointers, DataOut, pulses)
//   WrEn       write request, DataIn stored when not Full
//   DataIn     write data
//   RdEn       read request, DataOut loaded when not Empty
//   DataOut    registered read data, holds when no read is accepted
//   Full       queue holds 2^depthBits words
//   Empty      queue holds no words
//   Overflow   one-cycle pulse after a rejected write
//   Underflow  one-cycle pulse after a rejected read
//   Count      occupancy 0..2^depthBits, only when QUEUE_COUNT_EN is defined
// Optional feature macro: QUEUE_COUNT_EN adds the Count port.
module queue_fifo
  import queue_pkg::*;
#(
  parameter int numOfBit  = NUM_OF_BIT,
  parameter int depthBits = DEPTH_BITS
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                WrEn,
  input  logic [numOfBit-1:0] DataIn,
  input  logic                RdEn,
  output logic [numOfBit-1:0] DataOut,
  output logic                Full,
  output logic                Empty,
  output logic                Overflow,
`ifdef QUEUE_COUNT_EN
  output logic                Underflow,
  output logic [depthBits:0]  Count
`else
  output logic                Underflow
`endif
);

  localparam int Q_PTR_W = depthBits + 1;
  localparam int Q_DEPTH = 1 << depthBits;

  logic [Q_PTR_W-1:0]  wr_ptr;
  logic [Q_PTR_W-1:0]  rd_ptr;
  logic                wr_accept;
  logic                rd_accept;
  logic [numOfBit-1:0] mem [Q_DEPTH];

  // Status is decided purely from pointer equality: identical pointers mean
  // empty; same address with opposite wrap bits means a full lap ahead.
  assign Empty = (wr_ptr == rd_ptr);
  assign Full  = (wr_ptr[depthBits] != rd_ptr[depthBits]) &&
                 (wr_ptr[depthBits-1:0] == rd_ptr[depthBits-1:0]);

  assign wr_accept = WrEn && !Full;
  assign rd_accept = RdEn && !Empty;

  queue_ptr #(.W(Q_PTR_W)) u_wr_ptr (
    .clk   (Clk),
    .rst_n (Rst_n),
    .inc   (wr_accept),
    .ptr   (wr_ptr)
  );

  queue_ptr #(.W(Q_PTR_W)) u_rd_ptr (
    .clk   (Clk),
    .rst_n (Rst_n),
    .inc   (rd_accept),
    .ptr   (rd_ptr)
  );

  // Storage is deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge Clk) begin
    if (wr_accept) begin
      mem[wr_ptr[depthBits-1:0]] <= DataIn;
    end
  end

  // Registered read port; no bypass, so a word written on the same edge
  // that an empty queue is read is only visible on a later read.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      DataOut <= '0;
    end else if (rd_accept) begin
      DataOut <= mem[rd_ptr[depthBits-1:0]];
    end
  end

  // Rejection pulses are re-evaluated every edge, so they stay high across
  // back-to-back rejected requests and drop as soon as one is not rejected.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      Overflow  <= WrEn && Full;
      Underflow <= RdEn && Empty;
    end
  end

`ifdef QUEUE_COUNT_EN
  // Modular difference of the extended pointers gives 0..DEPTH directly.
  assign Count = wr_ptr - rd_ptr;
`endif

endmodule

// File: tb/tb_queue_fifo.sv
module tb_queue_fifo;

  localparam int W     = 10;
  localparam int DEPTH = 8;

  logic         Clk;
  logic         Rst_n;
  logic         WrEn;
  logic [W-1:0] DataIn;
  logic         RdEn;
  logic [W-1:0] DataOut;
  logic         Full;
  logic         Empty;
  logic         Overflow;
  logic         Underflow;
`ifdef QUEUE_COUNT_EN
  logic [3:0]   Count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of words plus the expected registered outputs.
  int           model_q[$];
  logic [W-1:0] exp_dout;
  logic         exp_ovf;
  logic         exp_udf;

  queue_fifo dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .WrEn      (WrEn),
    .DataIn    (DataIn),
    .RdEn      (RdEn),
    .DataOut   (DataOut),
    .Full      (Full),
    .Empty     (Empty),
    .Overflow  (Overflow),
`ifdef QUEUE_COUNT_EN
    .Underflow (Underflow),
    .Count     (Count)
`else
    .Underflow (Underflow)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive one cycle of requests, advance the model across the edge, sample 1 later.
  task automatic cycle(input logic we, input logic [W-1:0] din, input logic re);
    bit was_full, was_empty;
    WrEn   = we;
    DataIn = din;
    RdEn   = re;
    @(posedge Clk);
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    if (re && !was_empty) exp_dout = W'(model_q.pop_front());
    if (we && !was_full) model_q.push_back(int'(din));
    exp_ovf = we && was_full;
    exp_udf = re && was_empty;
    #1;
    WrEn = 1'b0;
    RdEn = 1'b0;
    $display("txn t=%0t we=%0b din=%03h re=%0b -> dout=%03h full=%0b empty=%0b ovf=%0b udf=%0b occ=%0d",
             $time, we, din, re, DataOut, Full, Empty, Overflow, Underflow, model_q.size());
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; WrEn = 1'b0; RdEn = 1'b0; DataIn = '0;
    model_q.delete(); exp_dout = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
    #12;
    Rst_n = 1'b1;
    cycle(1'b0, '0, 1'b0);
    checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", Empty); end
    checks++; if (Full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", Full); end
    checks++; if (DataOut !== '0) begin errors++; $display("FAIL reset_dout got=%03h exp=000", DataOut); end
    checks++; if (Overflow !== 1'b0 || Underflow !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%0b%0b exp=00", Overflow, Underflow); end
`ifdef QUEUE_COUNT_EN
    checks++; if (Count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", Count); end
`endif
  endtask

  task automatic test_underflow();
    cycle(1'b0, '0, 1'b1);
    checks++; if (Underflow !== 1'b1) begin errors++; $display("FAIL udf_pulse got=%0b exp=1", Underflow); end
    checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL udf_empty got=%0b exp=1", Empty); end
    cycle(1'b0, '0, 1'b0);
    checks++; if (Underflow !== 1'b0) begin errors++; $display("FAIL udf_drop got=%0b exp=0", Underflow); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, W'(i), 1'b0);
      checks++; if (Empty !== 1'b0 || Full !== (i == DEPTH)) begin
        errors++; $display("FAIL fill_flags i=%0d got full=%0b empty=%0b exp full=%0b empty=0", i, Full, Empty, (i == DEPTH));
      end
    end
`ifdef QUEUE_COUNT_EN
    checks++; if (Count !== 4'd8) begin errors++; $display("FAIL fill_count got=%0d exp=8", Count); end
`endif
    cycle(1'b1, 10'h3FF, 1'b0);
    checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%0b exp=1", Overflow); end
    checks++; if (Full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%0b exp=1", Full); end
    cycle(1'b0, '0, 1'b0);
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL ovf_drop got=%0b exp=0", Overflow); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1);
      checks++; if (DataOut !== W'(i)) begin errors++; $display("FAIL drain_data i=%0d got=%03h exp=%03h", i, DataOut, W'(i)); end
    end
    checks++; if (Empty !== 1'b1 || Full !== 1'b0) begin errors++; $display("FAIL drain_flags got full=%0b empty=%0b exp 0/1", Full, Empty); end
    cycle(1'b0, '0, 1'b0);
    checks++; if (DataOut !== W'(DEPTH)) begin errors++; $display("FAIL drain_hold got=%03h exp=%03h", DataOut, W'(DEPTH)); end
  endtask

  task automatic test_steady_wrap();
    for (int i = 0; i < 4; i++) cycle(1'b1, W'(10'h100 + i), 1'b0);
    for (int i = 4; i < 24; i++) begin
      cycle(1'b1, W'(10'h100 + i), 1'b1);
      checks++; if (DataOut !== exp_dout || DataOut !== W'(10'h100 + i - 4)) begin
        errors++; $display("FAIL wrap_data i=%0d got=%03h exp=%03h", i, DataOut, W'(10'h100 + i - 4));
      end
      checks++; if (Full !== 1'b0 || Empty !== 1'b0 || Overflow !== 1'b0 || Underflow !== 1'b0) begin
        errors++; $display("FAIL wrap_flags i=%0d got f=%0b e=%0b o=%0b u=%0b exp 0000", i, Full, Empty, Overflow, Underflow);
      end
`ifdef QUEUE_COUNT_EN
      checks++; if (Count !== 4'd4) begin errors++; $display("FAIL wrap_count got=%0d exp=4", Count); end
`endif
    end
  endtask

  task automatic test_simultaneous_edges();
    while (model_q.size() < DEPTH) cycle(1'b1, W'($urandom_range(0, 1023)), 1'b0);
    cycle(1'b1, 10'h2AA, 1'b1);
    checks++; if (Overflow !== 1'b1 || DataOut !== exp_dout || Full !== 1'b0) begin
      errors++; $display("FAIL full_both got ovf=%0b dout=%03h full=%0b exp ovf=1 dout=%03h full=0", Overflow, DataOut, Full, exp_dout);
    end
`ifdef QUEUE_COUNT_EN
    checks++; if (Count !== 4'd7) begin errors++; $display("FAIL full_both_count got=%0d exp=7", Count); end
`endif
    while (model_q.size() > 0) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 10'h155, 1'b1);
    checks++; if (Underflow !== 1'b1 || Empty !== 1'b0 || DataOut !== exp_dout) begin
      errors++; $display("FAIL empty_both got udf=%0b empty=%0b dout=%03h exp udf=1 empty=0 dout=%03h", Underflow, Empty, DataOut, exp_dout);
    end
`ifdef QUEUE_COUNT_EN
    checks++; if (Count !== 4'd1) begin errors++; $display("FAIL empty_both_count got=%0d exp=1", Count); end
`endif
    cycle(1'b0, '0, 1'b1);
    checks++; if (DataOut !== 10'h155) begin errors++; $display("FAIL empty_both_read got=%03h exp=155", DataOut); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      cycle(1'($urandom_range(0, 99) < 55), W'($urandom_range(0, 1023)), 1'($urandom_range(0, 99) < 50));
      checks++; if (DataOut !== exp_dout || Overflow !== exp_ovf || Underflow !== exp_udf ||
                    Full !== (model_q.size() == DEPTH) || Empty !== (model_q.size() == 0)) begin
        errors++; $display("FAIL random n=%0d got dout=%03h o=%0b u=%0b f=%0b e=%0b exp dout=%03h o=%0b u=%0b occ=%0d",
                           n, DataOut, Overflow, Underflow, Full, Empty, exp_dout, exp_ovf, exp_udf, model_q.size());
      end
`ifdef QUEUE_COUNT_EN
      checks++; if (Count !== 4'(model_q.size())) begin errors++; $display("FAIL random_count got=%0d exp=%0d", Count, model_q.size()); end
`endif
    end
  endtask

  task automatic test_async_reset();
    while (model_q.size() > 0) cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, W'(10'h0A0 + i), 1'b0);
    cycle(1'b0, '0, 1'b1);  // make DataOut non-zero before reset
    #2;
    Rst_n = 1'b0;
    #1;
    checks++; if (Empty !== 1'b1 || Full !== 1'b0 || DataOut !== '0 || Overflow !== 1'b0 || Underflow !== 1'b0) begin
      errors++; $display("FAIL async_reset got e=%0b f=%0b dout=%03h o=%0b u=%0b exp e=1 f=0 dout=000 o=0 u=0", Empty, Full, DataOut, Overflow, Underflow);
    end
`ifdef QUEUE_COUNT_EN
    checks++; if (Count !== 4'd0) begin errors++; $display("FAIL async_reset_count got=%0d exp=0", Count); end
`endif
    model_q.delete(); exp_dout = '0;
    #1;
    Rst_n = 1'b1;
    cycle(1'b1, 10'h077, 1'b0);
    cycle(1'b0, '0, 1'b1);
    checks++; if (DataOut !== 10'h077 || Empty !== 1'b1) begin
      errors++; $display("FAIL post_reset got dout=%03h empty=%0b exp 077/1", DataOut, Empty);
    end
  endtask

  initial begin
    test_reset();
    test_underflow();
    test_fill_overflow();
    test_drain();
    test_steady_wrap();
    test_simultaneous_edges();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
